// File: rtl/riscv_def.sv
// Shared RISC-V decode constants used by the multiplier and its writeback tracker.
package riscv_def;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } mul_funct3_e;

    // One multiply in flight: whether it will write, where, and from which pc.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] pc;
    } track_entry_t;

    function automatic logic is_mult_inst(input logic [31:0] opcode);
        logic [2:0] funct3;
        funct3 = opcode[14:12];
        return (opcode[6:0] == OPCODE_OP) && (opcode[31:25] == FUNCT7_MULDIV) &&
               ((funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                (funct3 == F3_MULHSU) || (funct3 == F3_MULHU));
    endfunction

endpackage

// File: rtl/mul_track_stage.sv
// One valid/rd/pc flop stage of the multiply tracker; kill clears valid even while held.
module mul_track_stage
    import riscv_def::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         kill,
    input  track_entry_t d,
    output track_entry_t q
);

    // NOTE: sequential state is written with <= so every stage samples the pre-edge
    // value of its neighbour; blocking here would collapse the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (kill) begin
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mul_wb_tracker.sv
// Shadows the multiplier pipeline with valid/rd/pc, qualifies its result into an
// RF write, drives the RAW busy mask, reports illegal instructions, counts retires.
module mul_wb_tracker
    import riscv_def::*;
#(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] opcode,
    input  logic [31:0] pc,
    input  logic        invalid,
    input  logic [4:0]  rd_idx,
    input  logic [4:0]  ra_idx,
    input  logic [4:0]  rb_idx,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] mul_value,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [31:0] rf_pc,
    output logic [31:0] busy_mask,
    output logic        stall_req,
    output logic        exc_illegal,
    output logic [31:0] exc_pc,
    output logic [31:0] mul_retired
);

    localparam int LAST = MULT_STAGES - 1;

    track_entry_t stage_d [MULT_STAGES];
    track_entry_t stage_q [MULT_STAGES];

    logic mult_inst;
    logic accept;
    logic illegal_seen;
    logic unused_opcode_bits;

    assign mult_inst          = is_mult_inst(opcode);
    assign unused_opcode_bits = ^{opcode[24:15], opcode[11:7]};
    assign accept             = valid & ~hold & ~invalid & mult_inst & ~stall_req & ~flush;
    assign illegal_seen       = valid & invalid & ~hold;

    for (genvar i = 0; i < MULT_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            // rd=0 multiplies still flow through the multiplier but are never tracked as writers.
            assign stage_d[i] = '{valid: accept && (rd_idx != 5'd0), rd: rd_idx, pc: pc};
        end else begin : g_shift
            // Flush must also stop a not-yet-completed entry from sliding into the last stage.
            assign stage_d[i] = '{valid: stage_q[i-1].valid & ~flush,
                                  rd:    stage_q[i-1].rd,
                                  pc:    stage_q[i-1].pc};
        end

        mul_track_stage u_stage (
            .clk  (clk),
            .rst  (rst),
            .hold (hold),
            .kill ((i < LAST) ? flush : 1'b0),
            .d    (stage_d[i]),
            .q    (stage_q[i])
        );
    end

    // NOTE: every always_comb output gets a default before any conditional write,
    // otherwise the unassigned paths infer latches.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < LAST; i++) begin
            if (stage_q[i].valid) begin
                busy_mask[stage_q[i].rd] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    assign stall_req = valid & ~hold & (busy_mask[ra_idx] | busy_mask[rb_idx]);

    // The last stage lines up with the multiplier result; hold suppresses the write.
    assign rf_we    = stage_q[LAST].valid & ~hold;
    assign rf_rd    = stage_q[LAST].rd;
    assign rf_pc    = stage_q[LAST].pc;
    assign rf_wdata = rf_we ? mul_value : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_illegal <= 1'b0;
            exc_pc      <= 32'd0;
            mul_retired <= 32'd0;
        end else begin
            exc_illegal <= illegal_seen;
            if (illegal_seen) begin
                exc_pc <= pc;
            end
            if (rf_we) begin
                mul_retired <= mul_retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mul_wb_tracker.sv
// Directed bench for mul_wb_tracker: a transaction-queue model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_mul_wb_tracker;

    localparam int MS = 2;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] opcode;
    logic [31:0] pc;
    logic        invalid;
    logic [4:0]  rd_idx;
    logic [4:0]  ra_idx;
    logic [4:0]  rb_idx;
    logic        hold;
    logic        flush;
    logic [31:0] mul_value;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] rf_pc;
    logic [31:0] busy_mask;
    logic        stall_req;
    logic        exc_illegal;
    logic [31:0] exc_pc;
    logic [31:0] mul_retired;

    int vectors;
    int miscompares;

    mul_wb_tracker #(.MULT_STAGES(MS)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .opcode      (opcode),
        .pc          (pc),
        .invalid     (invalid),
        .rd_idx      (rd_idx),
        .ra_idx      (ra_idx),
        .rb_idx      (rb_idx),
        .hold        (hold),
        .flush       (flush),
        .mul_value   (mul_value),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_pc       (rf_pc),
        .busy_mask   (busy_mask),
        .stall_req   (stall_req),
        .exc_illegal (exc_illegal),
        .exc_pc      (exc_pc),
        .mul_retired (mul_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Model: each tracked multiply is a record with how many edges it has advanced.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] pc;
        int          age;
    } inflight_t;

    inflight_t   mq[$];
    logic [31:0] m_retired;
    logic        m_exc;
    logic [31:0] m_exc_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    task automatic model_reset();
        mq        = {};
        m_retired = 32'd0;
        m_exc     = 1'b0;
        m_exc_pc  = 32'd0;
    endtask

    // Compare the DUT against the model for this cycle, then advance the model over the edge.
    task automatic model_step();
        inflight_t   nq[$];
        logic [31:0] busy;
        logic        has_ret;
        logic [4:0]  ret_rd;
        logic [31:0] ret_pc;
        logic        exp_we;
        logic        exp_stall;
        logic        is_mul;
        logic        acc;
        busy    = 32'd0;
        has_ret = 1'b0;
        ret_rd  = 5'd0;
        ret_pc  = 32'd0;
        foreach (mq[k]) begin
            if (mq[k].age == MS - 1) begin
                has_ret = 1'b1;
                ret_rd  = mq[k].rd;
                ret_pc  = mq[k].pc;
            end else begin
                busy[mq[k].rd] = 1'b1;
            end
        end
        exp_we    = has_ret & ~hold;
        exp_stall = valid & ~hold & (busy[ra_idx] | busy[rb_idx]);

        check("m_rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        if (exp_we) begin
            check("m_rf_rd", {27'd0, rf_rd}, {27'd0, ret_rd});
            check("m_rf_pc", rf_pc, ret_pc);
        end
        check("m_rf_wdata", rf_wdata, exp_we ? mul_value : 32'd0);
        check("m_busy_mask", busy_mask, busy);
        check("m_stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        check("m_exc_illegal", {31'd0, exc_illegal}, {31'd0, m_exc});
        check("m_exc_pc", exc_pc, m_exc_pc);
        check("m_mul_retired", mul_retired, m_retired);

        is_mul = (opcode[6:0] == 7'h33) && (opcode[31:25] == 7'h01) && (opcode[14:12] <= 3'd3);
        acc    = valid & ~hold & ~invalid & is_mul & ~exp_stall & ~flush;
        nq     = {};
        foreach (mq[k]) begin
            if (mq[k].age < MS - 1) begin
                if (!flush) begin
                    inflight_t e;
                    e = mq[k];
                    if (!hold) e.age++;
                    nq.push_back(e);
                end
            end else if (hold) begin
                nq.push_back(mq[k]);
            end
        end
        if (acc && rd_idx != 5'd0) nq.push_back('{rd: rd_idx, pc: pc, age: 0});
        mq = nq;
        if (exp_we) m_retired = m_retired + 32'd1;
        m_exc = valid & invalid & ~hold;
        if (m_exc) m_exc_pc = pc;
    endtask

    task automatic tick();
        #1;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        valid     = 1'b0;
        opcode    = 32'd0;
        pc        = 32'd0;
        invalid   = 1'b0;
        rd_idx    = 5'd0;
        ra_idx    = 5'd0;
        rb_idx    = 5'd0;
        hold      = 1'b0;
        flush     = 1'b0;
        mul_value = $urandom;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] p);
        idle();
        valid  = 1'b1;
        opcode = mk_r(f7, f3, rd, ra, rb);
        pc     = p;
        rd_idx = rd;
        ra_idx = ra;
        rb_idx = rb;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        check({tag, "_rf_rd"}, {27'd0, rf_rd}, 32'd0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        check({tag, "_rf_pc"}, rf_pc, 32'd0);
        check({tag, "_busy_mask"}, busy_mask, 32'd0);
        check({tag, "_stall_req"}, {31'd0, stall_req}, 32'd0);
        check({tag, "_exc_illegal"}, {31'd0, exc_illegal}, 32'd0);
        check({tag, "_exc_pc"}, exc_pc, 32'd0);
        check({tag, "_mul_retired"}, mul_retired, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle();
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // MUL x5,x1,x2: writes 0x12 to x5 in the cycle after the second edge.
        issue(7'h01, 3'd0, 5'd5, 5'd1, 5'd2, 32'h1000);
        tick();
        idle();
        #1;
        check("t1_busy", busy_mask, 32'h0000_0020);
        check("t1_we_early", {31'd0, rf_we}, 32'd0);
        tick();
        idle();
        mul_value = 32'h12;
        #1;
        check("t1_we", {31'd0, rf_we}, 32'd1);
        check("t1_rd", {27'd0, rf_rd}, 32'd5);
        check("t1_wdata", rf_wdata, 32'h12);
        check("t1_pc", rf_pc, 32'h1000);
        tick();
        idle();
        #1;
        check("t1_retired", mul_retired, 32'd1);
        tick();

        // MUL x3 then ADD x9,x3,x4: one stall cycle, ADD issues during the x3 write.
        issue(7'h01, 3'd0, 5'd3, 5'd1, 5'd2, 32'h1004);
        tick();
        issue(7'h00, 3'd0, 5'd9, 5'd3, 5'd4, 32'h1008);
        #1;
        check("t2_stall", {31'd0, stall_req}, 32'd1);
        check("t2_busy", busy_mask, 32'h0000_0008);
        tick();
        #1;
        check("t2_issue", {31'd0, stall_req}, 32'd0);
        check("t2_we", {31'd0, rf_we}, 32'd1);
        check("t2_rd", {27'd0, rf_rd}, 32'd3);
        tick();
        idle();
        tick();

        // MULH x0: occupies the pipe but is never busy and never writes.
        issue(7'h01, 3'd1, 5'd0, 5'd1, 5'd2, 32'h100c);
        tick();
        idle();
        #1;
        check("t3_busy", busy_mask, 32'd0);
        tick();
        #1;
        check("t3_we", {31'd0, rf_we}, 32'd0);
        tick();
        #1;
        check("t3_retired", mul_retired, 32'd2);
        tick();

        // MUL x7 then three hold cycles: the write slips by exactly three cycles.
        issue(7'h01, 3'd0, 5'd7, 5'd1, 5'd2, 32'h1010);
        tick();
        idle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_we_hold", {31'd0, rf_we}, 32'd0);
            tick();
        end
        hold = 1'b0;
        #1;
        check("t4_we_gap", {31'd0, rf_we}, 32'd0);
        check("t4_busy", busy_mask, 32'h0000_0080);
        tick();
        #1;
        check("t4_we", {31'd0, rf_we}, 32'd1);
        check("t4_rd", {27'd0, rf_rd}, 32'd7);
        tick();
        #1;
        check("t4_we_once", {31'd0, rf_we}, 32'd0);
        tick();

        // Hold in the retire cycle forces the write low and defers it.
        issue(7'h01, 3'd0, 5'd8, 5'd1, 5'd2, 32'h1014);
        tick();
        idle();
        tick();
        hold = 1'b1;
        #1;
        check("t4b_we_forced", {31'd0, rf_we}, 32'd0);
        tick();
        hold = 1'b0;
        #1;
        check("t4b_we", {31'd0, rf_we}, 32'd1);
        check("t4b_rd", {27'd0, rf_rd}, 32'd8);
        tick();

        // MUL x4, MUL x6 back-to-back, flush next cycle: only x4 writes.
        issue(7'h01, 3'd0, 5'd4, 5'd1, 5'd2, 32'h0200);
        tick();
        issue(7'h01, 3'd0, 5'd6, 5'd1, 5'd2, 32'h0204);
        tick();
        idle();
        flush = 1'b1;
        #1;
        check("t5_we_x4", {31'd0, rf_we}, 32'd1);
        check("t5_rd_x4", {27'd0, rf_rd}, 32'd4);
        tick();
        idle();
        #1;
        check("t5_no_x6", {31'd0, rf_we}, 32'd0);
        check("t5_busy", busy_mask, 32'd0);
        tick();
        #1;
        check("t5_no_x6_late", {31'd0, rf_we}, 32'd0);
        tick();

        // Flush with hold: the held retiring entry survives, the younger one dies.
        issue(7'h01, 3'd0, 5'd20, 5'd1, 5'd2, 32'h0300);
        tick();
        issue(7'h01, 3'd0, 5'd21, 5'd1, 5'd2, 32'h0304);
        tick();
        idle();
        hold  = 1'b1;
        flush = 1'b1;
        #1;
        check("t5b_we_held", {31'd0, rf_we}, 32'd0);
        check("t5b_busy", busy_mask, 32'h0020_0000);
        tick();
        idle();
        #1;
        check("t5b_we", {31'd0, rf_we}, 32'd1);
        check("t5b_rd", {27'd0, rf_rd}, 32'd20);
        check("t5b_busy_clr", busy_mask, 32'd0);
        tick();
        #1;
        check("t5b_no_x21", {31'd0, rf_we}, 32'd0);
        tick();

        // Back-to-back stream of all four multiply flavours: one retire per cycle.
        for (int i = 0; i < 6; i++) begin
            issue(7'h01, 3'(i % 4), 5'(13 + i), 5'd1, 5'd2, 32'h0400 + 32'(4 * i));
            tick();
        end
        idle();
        tick();
        tick();
        #1;
        check("t6_retired", mul_retired, 32'd12);
        tick();

        // Illegal MUL encoding: exception pulse and pc, never tracked.
        issue(7'h01, 3'd0, 5'd10, 5'd1, 5'd2, 32'h0100);
        invalid = 1'b1;
        tick();
        idle();
        #1;
        check("t7_exc", {31'd0, exc_illegal}, 32'd1);
        check("t7_exc_pc", exc_pc, 32'h0100);
        check("t7_busy", busy_mask, 32'd0);
        tick();
        #1;
        check("t7_exc_pulse", {31'd0, exc_illegal}, 32'd0);
        check("t7_exc_pc_held", exc_pc, 32'h0100);
        check("t7_no_we", {31'd0, rf_we}, 32'd0);
        tick();

        // Reset with two multiplies in flight discards both.
        issue(7'h01, 3'd0, 5'd11, 5'd1, 5'd2, 32'h0500);
        tick();
        issue(7'h01, 3'd0, 5'd12, 5'd1, 5'd2, 32'h0504);
        tick();
        idle();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t8_no_we", {31'd0, rf_we}, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
